// File: rtl/core_pkg.sv
// ---------------------------------------------------------------------------
// core_pkg
// Shared definitions for the operand-B path: select-code width and the
// operand-B select code constants. Used by the operand-B decoder, the
// stage register and the stage interface.
// ---------------------------------------------------------------------------
package core_pkg;

  // Width of the operand-B select code.
  localparam int SEL_W = 3;

  // Operand-B select codes. 110 and 111 are reserved (illegal).
  localparam logic [SEL_W-1:0] SEL_RS2 = 3'b000;
  localparam logic [SEL_W-1:0] SEL_I   = 3'b001;
  localparam logic [SEL_W-1:0] SEL_B   = 3'b010;
  localparam logic [SEL_W-1:0] SEL_S   = 3'b011;
  localparam logic [SEL_W-1:0] SEL_U   = 3'b100;
  localparam logic [SEL_W-1:0] SEL_UJ  = 3'b101;

endpackage : core_pkg

// File: rtl/op_b_stage_if.sv
// ---------------------------------------------------------------------------
// op_b_stage_if
// Handshake and data bundle of the operand-B stage.
//   master : upstream/downstream side (drives request, immediates,
//            forwarding, flush, out_ready; observes stage outputs)
//   slave  : the op_b_stage itself
// Signals:
//   in_valid/in_ready        request handshake
//   imme_sel                 operand-B select code
//   rs2, *_imme              candidate operand values
//   fwd_en/fwd_data          rs2 forwarding sources (source k at k*XLEN)
//   flush                    discard held and incoming request
//   out_valid/out_ready      operand handshake
//   op_b, sel_illegal        held operand and its illegal-select flag
//   illegal_cnt              saturating count of accepted illegal selects
// ---------------------------------------------------------------------------
interface op_b_stage_if
  import core_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int NUM_FWD = 2,
  parameter int CNT_W   = 8
);
  logic                    in_valid;
  logic                    in_ready;
  logic [SEL_W-1:0]        imme_sel;
  logic [XLEN-1:0]         rs2;
  logic [XLEN-1:0]         i_imme;
  logic [XLEN-1:0]         s_imme;
  logic [XLEN-1:0]         b_imme;
  logic [XLEN-1:0]         u_imme;
  logic [XLEN-1:0]         uj_imme;
  logic [NUM_FWD-1:0]      fwd_en;
  logic [NUM_FWD*XLEN-1:0] fwd_data;
  logic                    flush;
  logic                    out_valid;
  logic                    out_ready;
  logic [XLEN-1:0]         op_b;
  logic                    sel_illegal;
  logic [CNT_W-1:0]        illegal_cnt;

  modport master (
    output in_valid, imme_sel, rs2, i_imme, s_imme, b_imme, u_imme, uj_imme,
           fwd_en, fwd_data, flush, out_ready,
    input  in_ready, out_valid, op_b, sel_illegal, illegal_cnt
  );

  modport slave (
    input  in_valid, imme_sel, rs2, i_imme, s_imme, b_imme, u_imme, uj_imme,
           fwd_en, fwd_data, flush, out_ready,
    output in_ready, out_valid, op_b, sel_illegal, illegal_cnt
  );

endinterface : op_b_stage_if

// File: rtl/op_b_sel.sv
// ---------------------------------------------------------------------------
// op_b_sel
// Purely combinational operand-B decode with rs2 forwarding priority.
// Ports:
//   imme_sel_i   select code
//   rs2_i        register-file rs2 value
//   *_imme_i     pre-extended immediates
//   fwd_en_i     per-source forwarding hit (lowest index wins)
//   fwd_data_i   forwarding values, source k at [k*XLEN +: XLEN]
//   op_b_o       selected operand (zero for illegal codes)
//   illegal_o    1 when the select code is reserved
// ---------------------------------------------------------------------------
module op_b_sel
  import core_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int NUM_FWD = 2
) (
  input  logic [SEL_W-1:0]        imme_sel_i,
  input  logic [XLEN-1:0]         rs2_i,
  input  logic [XLEN-1:0]         i_imme_i,
  input  logic [XLEN-1:0]         s_imme_i,
  input  logic [XLEN-1:0]         b_imme_i,
  input  logic [XLEN-1:0]         u_imme_i,
  input  logic [XLEN-1:0]         uj_imme_i,
  input  logic [NUM_FWD-1:0]      fwd_en_i,
  input  logic [NUM_FWD*XLEN-1:0] fwd_data_i,
  output logic [XLEN-1:0]         op_b_o,
  output logic                    illegal_o
);

  logic [XLEN-1:0] fwd_val_s;
  logic            hit_s;

  // rs2 forwarding: first enabled source in ascending index order wins.
  always_comb begin
    fwd_val_s = rs2_i;
    hit_s     = 1'b0;
    for (int k = 0; k < NUM_FWD; k++) begin
      if (fwd_en_i[k] && !hit_s) begin
        hit_s     = 1'b1;
        fwd_val_s = fwd_data_i[k*XLEN +: XLEN];
      end else begin
        hit_s     = hit_s;
      end
    end
  end

  // Select decode; forwarding only matters for the rs2 code.
  always_comb begin
    op_b_o    = {XLEN{1'b0}};
    illegal_o = 1'b0;
    case (imme_sel_i)
      SEL_RS2: op_b_o = fwd_val_s;
      SEL_I:   op_b_o = i_imme_i;
      SEL_S:   op_b_o = s_imme_i;
      SEL_B:   op_b_o = b_imme_i;
      SEL_U:   op_b_o = u_imme_i;
      SEL_UJ:  op_b_o = uj_imme_i;
      default: begin
        op_b_o    = {XLEN{1'b0}};
        illegal_o = 1'b1;
      end
    endcase
  end

endmodule : op_b_sel

// File: rtl/op_b_stage.sv
// ---------------------------------------------------------------------------
// op_b_stage
// One-entry pipeline register for operand B with valid/ready handshake,
// flush, and a saturating counter of accepted illegal select codes.
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   bus   op_b_stage_if.slave (request, candidates, forwarding, flush,
//         output handshake, op_b, sel_illegal, illegal_cnt)
// in_ready is combinational; all other outputs are registered.
// ---------------------------------------------------------------------------
module op_b_stage
  import core_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int NUM_FWD = 2,
  parameter int CNT_W   = 8
) (
  input logic         clk,
  input logic         rst,
  op_b_stage_if.slave bus
);

  logic [XLEN-1:0]  sel_op_s;
  logic             sel_ill_s;
  logic             in_ready_s;
  logic             accept_s;
  logic             consume_s;

  logic             valid_q, valid_d;
  logic [XLEN-1:0]  op_b_q, op_b_d;
  logic             ill_q, ill_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  op_b_sel #(
    .XLEN    (XLEN),
    .NUM_FWD (NUM_FWD)
  ) u_sel (
    .imme_sel_i (bus.imme_sel),
    .rs2_i      (bus.rs2),
    .i_imme_i   (bus.i_imme),
    .s_imme_i   (bus.s_imme),
    .b_imme_i   (bus.b_imme),
    .u_imme_i   (bus.u_imme),
    .uj_imme_i  (bus.uj_imme),
    .fwd_en_i   (bus.fwd_en),
    .fwd_data_i (bus.fwd_data),
    .op_b_o     (sel_op_s),
    .illegal_o  (sel_ill_s)
  );

  // The slot can take a new entry when empty or being drained, unless flushed.
  assign in_ready_s = (!valid_q || bus.out_ready) && !bus.flush;
  assign accept_s   = bus.in_valid && in_ready_s;
  assign consume_s  = valid_q && bus.out_ready;

  // Next-state: flush beats accept, accept beats a plain consume.
  always_comb begin
    valid_d = valid_q;
    op_b_d  = op_b_q;
    ill_d   = ill_q;
    cnt_d   = cnt_q;
    if (bus.flush) begin
      valid_d = 1'b0;
    end else if (accept_s) begin
      valid_d = 1'b1;
      op_b_d  = sel_op_s;
      ill_d   = sel_ill_s;
      if (sel_ill_s && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_d = cnt_q + CNT_W'(1);
      end else begin
        cnt_d = cnt_q;
      end
    end else if (consume_s) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      op_b_q  <= {XLEN{1'b0}};
      ill_q   <= 1'b0;
      cnt_q   <= {CNT_W{1'b0}};
    end else begin
      valid_q <= valid_d;
      op_b_q  <= op_b_d;
      ill_q   <= ill_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.in_ready    = in_ready_s;
  assign bus.out_valid   = valid_q;
  assign bus.op_b        = op_b_q;
  assign bus.sel_illegal = ill_q;
  assign bus.illegal_cnt = cnt_q;

endmodule : op_b_stage

// File: tb/tb_op_b_stage.sv
// ---------------------------------------------------------------------------
// tb_op_b_stage
// Scoreboard bench for op_b_stage (XLEN=32, NUM_FWD=2, CNT_W=8).
// Expected operands are pushed when a request is accepted and popped when
// the stage presents the new entry.
// ---------------------------------------------------------------------------
module tb_op_b_stage;

  localparam int XLEN    = 32;
  localparam int NUM_FWD = 2;
  localparam int CNT_W   = 8;

  typedef struct {
    logic [XLEN-1:0] op;
    logic            ill;
  } exp_t;

  logic clk;
  logic rst;

  op_b_stage_if #(.XLEN(XLEN), .NUM_FWD(NUM_FWD), .CNT_W(CNT_W)) bif ();

  op_b_stage #(.XLEN(XLEN), .NUM_FWD(NUM_FWD), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t            sb[$];
  int              n_checks;
  int              n_errors;
  logic            m_valid;
  logic [XLEN-1:0] m_op;
  logic            m_ill;
  logic [CNT_W-1:0] m_cnt;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference operand for the currently driven request.
  function automatic exp_t ref_op();
    exp_t e;
    e.ill = 1'b0;
    case (bif.imme_sel)
      3'b000: begin
        if (bif.fwd_en[0])      e.op = bif.fwd_data[31:0];
        else if (bif.fwd_en[1]) e.op = bif.fwd_data[63:32];
        else                    e.op = bif.rs2;
      end
      3'b001:  e.op = bif.i_imme;
      3'b011:  e.op = bif.s_imme;
      3'b010:  e.op = bif.b_imme;
      3'b100:  e.op = bif.u_imme;
      3'b101:  e.op = bif.uj_imme;
      default: begin e.op = 32'h0; e.ill = 1'b1; end
    endcase
    return e;
  endfunction

  // One clock: called just after a negedge with inputs already driven.
  task automatic tick();
    logic exp_rdy, acc, cons;
    exp_t e;
    #1;
    exp_rdy = (!m_valid || bif.out_ready) && !bif.flush;
    check_val("in_ready", {63'd0, bif.in_ready}, {63'd0, exp_rdy});
    acc  = bif.in_valid && exp_rdy && !rst;
    cons = m_valid && bif.out_ready;
    if (acc) sb.push_back(ref_op());
    @(posedge clk);
    #1;
    if (rst) begin
      sb.delete();
      m_valid = 1'b0; m_op = 32'h0; m_ill = 1'b0; m_cnt = 8'd0;
    end else if (bif.flush) begin
      m_valid = 1'b0;
    end else if (acc) begin
      if (sb.size() == 0) begin
        check_val("sb_underflow", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        m_op = e.op; m_ill = e.ill; m_valid = 1'b1;
        if (e.ill && m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
      end
    end else if (cons) begin
      m_valid = 1'b0;
    end
    check_val("out_valid",   {63'd0, bif.out_valid},   {63'd0, m_valid});
    check_val("op_b",        {32'd0, bif.op_b},        {32'd0, m_op});
    check_val("sel_illegal", {63'd0, bif.sel_illegal}, {63'd0, m_ill});
    check_val("illegal_cnt", {56'd0, bif.illegal_cnt}, {56'd0, m_cnt});
    @(negedge clk);
  endtask

  task automatic rand_data();
    bif.rs2      = $urandom;
    bif.i_imme   = $urandom;
    bif.s_imme   = $urandom;
    bif.b_imme   = $urandom;
    bif.u_imme   = $urandom;
    bif.uj_imme  = $urandom;
    bif.fwd_data = {$urandom, $urandom};
    bif.fwd_en   = 2'($urandom_range(0, 3));
  endtask

  initial begin
    n_checks = 0; n_errors = 0;
    m_valid = 1'b0; m_op = 32'h0; m_ill = 1'b0; m_cnt = 8'd0;
    rst = 1'b1;
    bif.in_valid = 1'b0; bif.imme_sel = 3'b000; bif.rs2 = 32'h0;
    bif.i_imme = 32'h0; bif.s_imme = 32'h0; bif.b_imme = 32'h0;
    bif.u_imme = 32'h0; bif.uj_imme = 32'h0; bif.fwd_en = 2'b00;
    bif.fwd_data = 64'h0; bif.flush = 1'b0; bif.out_ready = 1'b0;
    @(negedge clk);
    tick(); tick();
    rst = 1'b0;
    tick();  // idle after reset: in_ready must be 1, outputs zero

    // First transaction: i_imme through, latency one cycle.
    bif.imme_sel = 3'b001; bif.i_imme = 32'h0000_0010;
    bif.in_valid = 1'b1; bif.out_ready = 1'b1;
    tick();

    // Forwarding priority and ignoring fwd_en for immediates.
    bif.rs2 = 32'h5; bif.fwd_data = {32'hB, 32'hA};
    bif.imme_sel = 3'b000; bif.fwd_en = 2'b11; tick();
    bif.fwd_en = 2'b10; tick();
    bif.fwd_en = 2'b00; tick();
    bif.imme_sel = 3'b001; bif.fwd_en = 2'b11; tick();

    // Every select code, back-to-back with full throughput.
    for (int s = 0; s < 8; s++) begin
      rand_data();
      bif.imme_sel = 3'(s);
      tick();
    end

    // Downstream stall for 3 cycles: op_b stable, no accept.
    bif.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rand_data();
      bif.imme_sel = 3'(i + 3);
      tick();
    end

    // Flush while stalled with a pending request: entry dropped, no accept.
    bif.flush = 1'b1; tick();
    bif.flush = 1'b0; bif.in_valid = 1'b0; tick();
    bif.out_ready = 1'b1; tick();  // empty, nothing consumed

    // Illegal select 300 times: counter saturates at 255.
    bif.in_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      rand_data();
      bif.imme_sel = (i % 7 == 0) ? 3'b111 : 3'b110;
      tick();
    end
    check_val("cnt_sat", {56'd0, bif.illegal_cnt}, 64'd255);

    // Random traffic including stalls, flushes and idle cycles.
    for (int i = 0; i < 200; i++) begin
      rand_data();
      bif.imme_sel  = 3'($urandom_range(0, 7));
      bif.in_valid  = 1'($urandom_range(0, 3) != 0);
      bif.out_ready = 1'($urandom_range(0, 2) != 0);
      bif.flush     = 1'($urandom_range(0, 9) == 0);
      tick();
    end

    // Reset mid-stream with flush and in_valid high: everything zero.
    bif.flush = 1'b0; bif.in_valid = 1'b1; bif.out_ready = 1'b0;
    bif.imme_sel = 3'b110; tick();
    rst = 1'b1; bif.flush = 1'b1; tick();
    rst = 1'b0; bif.flush = 1'b0; bif.in_valid = 1'b0;
    check_val("rst_cnt", {56'd0, bif.illegal_cnt}, 64'd0);
    check_val("rst_valid", {63'd0, bif.out_valid}, 64'd0);
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_op_b_stage

// File: doc/op_b_stage.md
OP_B_STAGE -- requirements
Module: op_b_stage

Interface
REQ-001 Parameter XLEN, default 32, operand/immediate datapath width in bits.
REQ-002 Parameter NUM_FWD, default 2, number of forwarding sources for rs2 (1..4).
REQ-003 Parameter CNT_W, default 8, width of the illegal-select counter.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 in_valid  input  1  upstream holds a valid operand request.
REQ-007 in_ready  output  1  stage can accept a request this cycle.
REQ-008 imme_sel  input  3  operand-B select code.
REQ-009 rs2  input  XLEN  register-file rs2 value.
REQ-010 i_imme, s_imme, b_imme, u_imme, uj_imme  input  XLEN each  pre-extended immediates.
REQ-011 fwd_en  input  NUM_FWD  per-source forwarding hit for rs2.
REQ-012 fwd_data  input  NUM_FWD*XLEN  forwarding values, source k at bits [k*XLEN +: XLEN].
REQ-013 flush  input  1  discard held and incoming request.
REQ-014 out_valid  output  1  op_b register holds a valid operand.
REQ-015 out_ready  input  1  downstream consumes op_b this cycle.
REQ-016 op_b  output  XLEN  registered operand B.
REQ-017 sel_illegal  output  1  registered flag: held operand came from an illegal select code.
REQ-018 illegal_cnt  output  CNT_W  saturating count of accepted illegal selects.

Function
REQ-019 Select decode SHALL be: 000 rs2 path, 001 i_imme, 011 s_imme, 010 b_imme, 100 u_imme, 101 uj_imme; 110/111 illegal.
REQ-020 rs2 path SHALL return fwd_data of the lowest-index k with fwd_en[k]=1, else rs2; fwd_en SHALL be ignored for non-rs2 codes.
REQ-021 Illegal codes SHALL yield op_b = 0 and sel_illegal = 1; legal codes SHALL yield sel_illegal = 0; decode SHALL be fully specified (no latch, no X).
REQ-022 in_ready SHALL equal (!out_valid || out_ready) && !flush, combinationally.
REQ-023 Accept SHALL occur when in_valid && in_ready; on accept op_b and sel_illegal SHALL load on the next edge and out_valid SHALL be 1 (latency 1 cycle).
REQ-024 Simultaneous accept and downstream consume SHALL replace the held entry with no bubble (full throughput, one op per cycle).
REQ-025 out_valid && !out_ready SHALL hold op_b, sel_illegal, out_valid stable.
REQ-026 Consume without accept SHALL clear out_valid; op_b SHALL keep its last value.
REQ-027 flush SHALL clear out_valid on the next edge and block accept in the same cycle; flush has priority over all transfers.
REQ-028 illegal_cnt SHALL increment by 1 on each accepted illegal code and SHALL saturate at 2^CNT_W-1; flush SHALL NOT alter it.
REQ-029 Inputs other than in_valid/flush SHALL be ignored when no accept occurs.

Reset
REQ-030 rst SHALL set out_valid=0, op_b=0, sel_illegal=0, illegal_cnt=0 on the next edge.
REQ-031 rst SHALL override flush, accept and consume in the same cycle; an in-flight operand SHALL be discarded.
REQ-032 in_ready SHALL be 1 in the cycle after reset deasserts (absent flush).

Structure
REQ-033 Select code constants (SEL_RS2, SEL_I, SEL_B, SEL_S, SEL_U, SEL_UJ) SHALL live in a shared package core_pkg used also by the decoder.
REQ-034 The combinational decode+forward priority SHALL be one sub-module, op_b_sel, instantiated once; op_b_stage holds only the register, handshake and counter.

Verification
REQ-035 Reset then sel=001, i_imme=0x0000_0010, in_valid=1, out_ready=1 -> next cycle out_valid=1, op_b=0x10, sel_illegal=0.
REQ-036 sel=000, rs2=0x5, fwd_en=2'b11, fwd_data={0xB,0xA} -> op_b=0xA; fwd_en=2'b10 -> op_b=0xB; sel=001 with fwd_en=2'b11 -> op_b=i_imme.
REQ-037 Back-to-back 4 accepts with out_ready=1 -> 4 consecutive out_valid cycles, values in order; out_ready=0 for 3 cycles -> op_b stable, in_ready=0.
REQ-038 sel=110 accepted 300 times (CNT_W=8) -> op_b=0, sel_illegal=1 each, illegal_cnt ends at 255.
REQ-039 out_valid=1, out_ready=0, flush=1 with in_valid=1 -> next cycle out_valid=0, no accept; rst mid-stream with flush and in_valid high -> all outputs 0.
